imem_loader: RTL and testbench

Boot-time writer for the core's byte-addressed instruction memory. Accepts a byte stream on a valid/ready handshake and packs each four bytes into a little-endian `XLEN word. Writes the words through a RAM write port at word-aligned addresses from 0 upward, then checks a trailing XOR checksum. Holds the core in reset until a load completes cleanly; it is the writer end of the instruction-fetch read port.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared widths and FSM state type for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned ADDRLEN = 32;
    localparam int unsigned XLEN    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, RAM write port and load status of the boot loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = imem_loader_pkg::ADDRLEN,
    parameter int unsigned DATA_W = imem_loader_pkg::XLEN
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into little-endian words,
// writes them to instruction RAM from address 0 and verifies an XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDRLEN,
    parameter int unsigned MAX_WORDS = 2**(ADDR_W-2)
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    localparam logic [1:0] LAST_BYTE = 2'd3;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_nlo;
    logic [15:0]         r_rem;
    logic [1:0]          r_bcnt;
    logic [7:0]          r_xor;
    logic [XLEN-1:0]     r_pack;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_ready;
    logic                w_xfer;
    logic [15:0]         w_n;
    logic                w_restart;

    assign w_ready   = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer    = w_ready && bus.in_valid;
    assign w_n       = {bus.in_data, r_nlo};
    assign w_restart = bus.start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) w_next = S_HDR0;
            end
            S_HDR0: begin
                if (w_xfer) w_next = S_HDR1;
            end
            S_HDR1: begin
                if (w_xfer) begin
                    if (32'(w_n) > MAX_WORDS) w_next = S_ERR;
                    else if (w_n == 16'd0)    w_next = S_CSUM;
                    else                      w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && (r_bcnt == LAST_BYTE)) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = (r_rem == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_xfer) w_next = (bus.in_data == r_xor) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bytes enter at the top and shift down, so stream byte 0 lands in [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nlo  <= '0;
            r_rem  <= '0;
            r_bcnt <= '0;
            r_xor  <= '0;
            r_pack <= '0;
            r_addr <= '0;
        end else begin
            if (w_restart) begin
                r_addr <= '0;
                r_xor  <= '0;
                r_bcnt <= '0;
            end
            if (w_xfer) begin
                unique case (r_state)
                    S_HDR0: r_nlo <= bus.in_data;
                    S_HDR1: r_rem <= w_n;
                    S_DATA: begin
                        r_pack <= {bus.in_data, r_pack[XLEN-1:8]};
                        r_xor  <= r_xor ^ bus.in_data;
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (r_state == S_WRITE) begin
                r_addr <= r_addr + ADDR_W'(4);
                r_rem  <= r_rem - 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_pack;
    assign bus.core_hold = (r_state != S_DONE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned MAXW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]    stream[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int            exp_nw;
    bit            exp_done;
    int            n_writes = 0;

    // Reference: the whole load outcome follows directly from the byte stream.
    function automatic void build_model();
        int         n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n  = int'({stream[1], stream[0]});
        x  = 8'h00;
        exp_nw = 0;
        if (n > int'(MAXW)) begin
            exp_done = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(AW'(4 * i));
            exp_data.push_back({stream[4*i+5], stream[4*i+4], stream[4*i+3], stream[4*i+2]});
            for (int k = 0; k < 4; k++) x ^= stream[4*i+2+k];
        end
        exp_nw   = n;
        exp_done = (stream[2 + 4*n] == x);
    endfunction

    task automatic make_stream(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        if (n > int'(MAXW)) return;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x ^= b;
        end
        stream.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            n_writes++;
            check_eq("wr_ready_low", 32'(bus.in_ready), 32'd0);
            if (exp_addr.size() == 0) begin
                check_eq("wr_unexpected", 32'(bus.mem_we), 32'd0);
            end else begin
                check_eq("wr_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
                check_eq("wr_data", bus.mem_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("start_ready", 32'(bus.in_ready),  32'd1);
        check_eq("start_hold",  32'(bus.core_hold), 32'd1);
        check_eq("start_done",  32'(bus.done),      32'd0);
        check_eq("start_err",   32'(bus.err),       32'd0);
    endtask

    // Offers stream bytes with random gaps and stray start pulses, which must be ignored.
    task automatic drive(input int pct, input int limit);
        int idx = 0;
        int cyc = 0;
        bit fire;
        while (idx < limit && cyc < 4000) begin
            bus.in_valid = ($urandom_range(99) < pct);
            bus.in_data  = bus.in_valid ? stream[idx] : 8'($urandom);
            bus.start    = ($urandom_range(19) == 0);
            fire = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (fire) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (idx < limit) check_eq("timeout", 32'(idx), 32'(limit));
    endtask

    task automatic run_load(input int pct);
        int w0;
        build_model();
        w0 = n_writes;
        pulse_start();
        drive(pct, stream.size());
        check_eq("out_done",  32'(bus.done),      32'(exp_done));
        check_eq("out_err",   32'(bus.err),       32'(!exp_done));
        check_eq("out_hold",  32'(bus.core_hold), 32'(!exp_done));
        check_eq("out_ready", 32'(bus.in_ready),  32'd0);
        check_eq("wr_count",  32'(n_writes - w0), 32'(exp_nw));
        repeat (5) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_eq("idle_writes", 32'(n_writes - w0), 32'(exp_nw));
        check_eq("idle_done",   32'(bus.done),      32'(exp_done));
    endtask

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        #12;
        check_eq("rst_ready", 32'(bus.in_ready),  32'd0);
        check_eq("rst_we",    32'(bus.mem_we),    32'd0);
        check_eq("rst_addr",  32'(bus.mem_addr),  32'd0);
        check_eq("rst_wdata", bus.mem_wdata,      32'd0);
        check_eq("rst_hold",  32'(bus.core_hold), 32'd1);
        check_eq("rst_done",  32'(bus.done),      32'd0);
        check_eq("rst_err",   32'(bus.err),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        stream = '{8'h02, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00, 8'h13, 8'h03, 8'hB0, 8'h00, 8'h11};
        run_load(100);
        stream = '{8'h02, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00, 8'h13, 8'h03, 8'hB0, 8'h00, 8'h12};
        run_load(100);
        stream = '{8'h00, 8'h00, 8'h00};
        run_load(100);
        stream = '{8'h41, 8'h00};
        run_load(100);
        stream = '{8'h40, 8'h00};
        make_stream(64, 1'b1);
        run_load(100);
        stream = '{8'h02, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00, 8'h13, 8'h03, 8'hB0, 8'h00, 8'h11};
        run_load(50);

        // Reset after two payload bytes: nothing may be written.
        make_stream(2, 1'b1);
        build_model();
        n = n_writes;
        pulse_start();
        drive(100, 4);
        rst_n = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        #1;
        check_eq("mrst_ready", 32'(bus.in_ready),  32'd0);
        check_eq("mrst_we",    32'(bus.mem_we),    32'd0);
        check_eq("mrst_addr",  32'(bus.mem_addr),  32'd0);
        check_eq("mrst_wdata", bus.mem_wdata,      32'd0);
        check_eq("mrst_hold",  32'(bus.core_hold), 32'd1);
        check_eq("mrst_done",  32'(bus.done),      32'd0);
        check_eq("mrst_err",   32'(bus.err),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mrst_nowrite", 32'(n_writes - n), 32'd0);
        make_stream(3, 1'b1);
        run_load(70);
        make_stream(2, 1'b1);
        run_load(60);

        for (int t = 0; t < 30; t++) begin
            n = ($urandom_range(7) == 0) ? (65 + int'($urandom_range(65470))) : int'($urandom_range(6));
            make_stream(n, ($urandom_range(3) != 0));
            run_load(30 + int'($urandom_range(70)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
